// File: rtl/line_engine.sv
// Bresenham line rasterizer: captures endpoints and a colour from CPU strobes,
// then emits one frame-buffer pixel write per accepted handshake.
module line_engine #(
  parameter logic [31:0] FB_BASE = 32'h1800_0000,
  parameter int          COORD_W = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [31:0]        line_color,
  input  logic [COORD_W-1:0] line_point,
  input  logic               line_color_valid,
  input  logic               line_x0_valid,
  input  logic               line_y0_valid,
  input  logic               line_x1_valid,
  input  logic               line_y1_valid,
  input  logic               line_trigger,
  output logic               line_ready,
  output logic [31:0]        px_addr,
  output logic [31:0]        px_data,
  output logic [3:0]         px_we,
  output logic               px_valid,
  input  logic               px_ready
);
  localparam int DW  = COORD_W + 1;
  localparam int EW  = COORD_W + 2;
  localparam int E2W = COORD_W + 3;
  localparam int AW  = 2 * COORD_W + 2;

  typedef enum logic [1:0] {IDLE, SETUP, DRAW} state_t;

  state_t               state;
  logic [COORD_W-1:0]   x0, y0, x1, y1, cur_x, cur_y;
  logic [31:0]          color;
  logic signed [DW-1:0] dx, dy;
  logic signed [EW-1:0] err;
  logic                 sx_neg, sy_neg;

  function automatic logic [31:0] pix_addr(input logic [COORD_W-1:0] x, input logic [COORD_W-1:0] y);
    return FB_BASE | {{(32-AW){1'b0}}, y, x, 2'b00};
  endfunction

  // Line geometry derived from the captured endpoints, used in SETUP.
  logic signed [DW-1:0] diff_x, diff_y, abs_x, abs_y;
  assign diff_x = $signed({1'b0, x1}) - $signed({1'b0, x0});
  assign diff_y = $signed({1'b0, y1}) - $signed({1'b0, y0});
  assign abs_x  = diff_x[DW-1] ? -diff_x : diff_x;
  assign abs_y  = diff_y[DW-1] ? -diff_y : diff_y;

  // One Bresenham step from the current point; both axes use the pre-update err.
  logic signed [E2W-1:0] e2, dx_w, dy_w;
  logic signed [EW-1:0]  err_add_x, err_add_y, err_next;
  logic                  step_x, step_y, at_end;
  logic [COORD_W-1:0]    nx, ny;

  assign e2        = {err, 1'b0};
  assign dx_w      = {{2{dx[DW-1]}}, dx};
  assign dy_w      = {{2{dy[DW-1]}}, dy};
  assign step_x    = (e2 >= dy_w);
  assign step_y    = (e2 <= dx_w);
  assign err_add_x = step_x ? {dy[DW-1], dy} : '0;
  assign err_add_y = step_y ? {dx[DW-1], dx} : '0;
  assign err_next  = err + err_add_x + err_add_y;
  assign nx        = step_x ? (sx_neg ? cur_x - 1'b1 : cur_x + 1'b1) : cur_x;
  assign ny        = step_y ? (sy_neg ? cur_y - 1'b1 : cur_y + 1'b1) : cur_y;
  assign at_end    = (cur_x == x1) && (cur_y == y1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      x0         <= '0;
      y0         <= '0;
      x1         <= '0;
      y1         <= '0;
      color      <= '0;
      cur_x      <= '0;
      cur_y      <= '0;
      dx         <= '0;
      dy         <= '0;
      err        <= '0;
      sx_neg     <= 1'b0;
      sy_neg     <= 1'b0;
      line_ready <= 1'b1;
      px_valid   <= 1'b0;
      px_addr    <= '0;
      px_data    <= '0;
      px_we      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (line_x0_valid)    x0    <= line_point;
          if (line_y0_valid)    y0    <= line_point;
          if (line_x1_valid)    x1    <= line_point;
          if (line_y1_valid)    y1    <= line_point;
          if (line_color_valid) color <= line_color;
          if (line_trigger) begin
            state      <= SETUP;
            line_ready <= 1'b0;
          end
        end
        SETUP: begin
          dx       <= abs_x;
          dy       <= -abs_y;
          err      <= {abs_x[DW-1], abs_x} - {abs_y[DW-1], abs_y};
          sx_neg   <= !(x0 < x1);
          sy_neg   <= !(y0 < y1);
          cur_x    <= x0;
          cur_y    <= y0;
          px_addr  <= pix_addr(x0, y0);
          px_data  <= color;
          px_we    <= 4'hF;
          px_valid <= 1'b1;
          state    <= DRAW;
        end
        DRAW: begin
          if (px_ready) begin
            if (at_end) begin
              px_valid   <= 1'b0;
              line_ready <= 1'b1;
              state      <= IDLE;
            end else begin
              err     <= err_next;
              cur_x   <= nx;
              cur_y   <= ny;
              px_addr <= pix_addr(nx, ny);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_line_engine.sv
// Randomised self-checking bench for line_engine against a pixel-list reference model.
module tb_line_engine;
  localparam logic [31:0] FB_BASE = 32'h1800_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] line_color = '0;
  logic [9:0]  line_point = '0;
  logic        line_color_valid = 0, line_x0_valid = 0, line_y0_valid = 0;
  logic        line_x1_valid = 0, line_y1_valid = 0, line_trigger = 0;
  logic        line_ready, px_valid;
  logic [31:0] px_addr, px_data;
  logic [3:0]  px_we;
  logic        px_ready = 1'b1;

  line_engine #(.FB_BASE(FB_BASE), .COORD_W(10)) dut (
    .clk(clk), .rst_n(rst_n), .line_color(line_color), .line_point(line_point),
    .line_color_valid(line_color_valid), .line_x0_valid(line_x0_valid),
    .line_y0_valid(line_y0_valid), .line_x1_valid(line_x1_valid),
    .line_y1_valid(line_y1_valid), .line_trigger(line_trigger),
    .line_ready(line_ready), .px_addr(px_addr), .px_data(px_data),
    .px_we(px_we), .px_valid(px_valid), .px_ready(px_ready)
  );

  always #5 clk = ~clk;

  int          tests = 0, fails = 0;
  int          ready_mode = 0;   // 0: always ready, 1: toggle 1010..., 2: random
  logic [31:0] exp_q[$];
  logic [31:0] mq[$];
  logic [31:0] exp_color = '0;
  int          m_x0 = 0, m_y0 = 0, m_x1 = 0, m_y1 = 0;
  logic [31:0] m_col = '0;

  function automatic logic [31:0] addr_of(input int x, input int y);
    return FB_BASE | (y << 12) | (x << 2);
  endfunction

  // Reference: the ordered list of pixel addresses the line must produce.
  task automatic model(input int x0, input int y0, input int x1, input int y1);
    int dx, dy, err, e2, x, y, sx, sy;
    mq.delete();
    dx = (x1 > x0) ? x1 - x0 : x0 - x1;
    dy = (y1 > y0) ? y0 - y1 : y1 - y0;
    sx = (x0 < x1) ? 1 : -1;
    sy = (y0 < y1) ? 1 : -1;
    err = dx + dy; x = x0; y = y0;
    forever begin
      mq.push_back(addr_of(x, y));
      if (x == x1 && y == y1) break;
      e2 = 2 * err;
      if (e2 >= dy) begin err += dy; x += sx; end
      if (e2 <= dx) begin err += dx; y += sy; end
    end
  endtask

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h, want %h", nm, got, want);
    end
  endtask

  task automatic pin(input string nm, input int n, input logic [31:0] w0, input logic [31:0] w1,
                     input logic [31:0] w2, input logic [31:0] w3);
    logic [31:0] w[4];
    w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
    check({nm, "_count"}, mq.size(), n);
    for (int i = 0; i < n && i < mq.size(); i++) check(nm, mq[i], w[i]);
  endtask

  // px_ready driver, changed just after each rising edge.
  initial forever begin
    @(posedge clk); #1;
    case (ready_mode)
      0: px_ready = 1'b1;
      1: px_ready = ~px_ready;
      default: px_ready = ($urandom_range(0, 9) < 7);
    endcase
  end

  // Compare process: every handshake against the model, every stall for stability.
  logic [31:0] st_addr, st_data;
  bit          stalled = 0;
  initial forever begin
    @(negedge clk);
    if (!rst_n) stalled = 0;
    else begin
      if (stalled) begin
        tests++;
        if (!px_valid || px_addr !== st_addr || px_data !== st_data || px_we !== 4'hF) begin
          fails++;
          $display("FAIL stall_hold: valid=%b addr=%h data=%h, want valid=1 addr=%h data=%h",
                   px_valid, px_addr, px_data, st_addr, st_data);
        end
      end
      stalled = px_valid && !px_ready;
      st_addr = px_addr; st_data = px_data;
      if (px_valid && px_ready) begin
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL extra_pixel: addr=%h, want no pixel", px_addr);
        end else begin
          check("px_addr", px_addr, exp_q.pop_front());
          check("px_data", px_data, exp_color);
          check("px_we", {28'h0, px_we}, 32'hF);
        end
      end
    end
  end

  task automatic draw(input bit load, input int ax0, input int ay0, input int ax1, input int ay1,
                      input logic [31:0] col, input int pulse_k, input int abort_k, output int lat);
    int k, first_v, n;
    bit done, aborted;
    if (load) begin m_x0 = ax0; m_y0 = ay0; m_x1 = ax1; m_y1 = ay1; m_col = col; end
    model(m_x0, m_y0, m_x1, m_y1);
    n = mq.size();
    foreach (mq[i]) exp_q.push_back(mq[i]);
    exp_color = m_col;
    check("ready_before", {31'h0, line_ready}, 32'h1);
    if (load) begin
      line_point = ax0[9:0]; line_x0_valid = 1; line_color = col; line_color_valid = 1;
      @(posedge clk); #1; line_x0_valid = 0; line_color_valid = 0;
      line_point = ay0[9:0]; line_y0_valid = 1;
      @(posedge clk); #1; line_y0_valid = 0;
      line_point = ax1[9:0]; line_x1_valid = 1;
      @(posedge clk); #1; line_x1_valid = 0;
      line_point = ay1[9:0]; line_y1_valid = 1;
    end
    line_trigger = 1;
    @(posedge clk); #1;
    line_trigger = 0; line_y1_valid = 0;
    k = 0; first_v = 0; done = 0; aborted = 0;
    while (!done && k < 4000) begin
      @(negedge clk); k++;
      if (px_valid && first_v == 0) first_v = k;
      if (k == pulse_k) begin line_point = 10'd100; line_x1_valid = 1; end
      else line_x1_valid = 0;
      if (k == abort_k) begin
        rst_n = 0; #1;
        check("abort_valid", {31'h0, px_valid}, 32'h0);
        check("abort_ready", {31'h0, line_ready}, 32'h1);
        exp_q.delete();
        m_x0 = 0; m_y0 = 0; m_x1 = 0; m_y1 = 0; m_col = '0;
        done = 1; aborted = 1;
      end else if (line_ready) done = 1;
    end
    line_x1_valid = 0;
    lat = k;
    if (!aborted) begin
      tests++;
      if (!done || exp_q.size() != 0 || px_valid) begin
        fails++;
        $display("FAIL line_end: done=%0d left=%0d valid=%b, want done=1 left=0 valid=0",
                 done, exp_q.size(), px_valid);
        exp_q.delete();
      end
      check("first_valid_cycle", first_v, 2);
      if (ready_mode == 0) check("line_latency", lat, n + 2);
    end
  endtask

  int lat;
  initial begin
    #23 rst_n = 1;
    @(negedge clk);
    check("rst_ready", {31'h0, line_ready}, 32'h1);
    check("rst_valid", {31'h0, px_valid}, 32'h0);
    check("rst_addr", px_addr, 32'h0);
    check("rst_data", px_data, 32'h0);
    check("rst_we", {28'h0, px_we}, 32'h0);

    model(0, 0, 3, 0);
    pin("pin_horiz", 4, FB_BASE, FB_BASE + 4, FB_BASE + 8, FB_BASE + 12);
    model(5, 5, 2, 2);
    pin("pin_rdiag", 4, FB_BASE | 32'h5014, FB_BASE | 32'h4010, FB_BASE | 32'h300C, FB_BASE | 32'h2008);
    model(0, 0, 1, 3);
    pin("pin_steep", 4, FB_BASE, FB_BASE | 32'h1000, FB_BASE | 32'h2004, FB_BASE | 32'h3004);
    model(7, 9, 7, 9);
    pin("pin_point", 1, FB_BASE | 32'h901C, 0, 0, 0);

    ready_mode = 0;
    draw(1, 0, 0, 3, 0, 32'h00FF0000, 0, 0, lat);
    check("horiz_ready_after", lat, 6);
    draw(1, 5, 5, 2, 2, 32'h0000FF00, 0, 0, lat);
    draw(1, 0, 0, 1, 3, 32'h000000FF, 0, 0, lat);
    draw(1, 7, 9, 7, 9, 32'h12345678, 0, 0, lat);
    check("point_ready_after", lat, 3);

    ready_mode = 1;
    draw(1, 0, 0, 3, 0, 32'h00FF0000, 3, 0, lat);
    draw(0, 0, 0, 0, 0, 0, 0, 0, lat);

    ready_mode = 0;
    draw(1, 0, 0, 9, 0, 32'hCAFEF00D, 0, 3, lat);
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    check("post_rst_addr", px_addr, 32'h0);
    check("post_rst_ready", {31'h0, line_ready}, 32'h1);
    draw(0, 0, 0, 0, 0, 0, 0, 0, lat);
    check("post_rst_latency", lat, 3);

    for (int i = 0; i < 30; i++) begin
      int lim;
      ready_mode = (i % 3 == 0) ? 0 : 2;
      lim = (i % 2 == 0) ? 40 : 1023;
      draw(1, $urandom_range(0, lim), $urandom_range(0, lim), $urandom_range(0, lim),
           $urandom_range(0, lim), $urandom, 0, 0, lat);
      if (i % 5 == 4) draw(0, 0, 0, 0, 0, 0, 0, 0, lat);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL timeout: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "timeout");
  end
endmodule
